// File: rtl/pixel_fetch_pkg.sv
// Shared types and constants for the pixel fetch engine (FSM states, width defaults, blank pixel).
package pixel_fetch_pkg;
  localparam int ADDR_W_DEF  = 19;
  localparam int DATA_W_DEF  = 16;
  localparam int BLANK_PIXEL = 0;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    ISSUE,
    CAPTURE
  } state_t;
endpackage

// File: rtl/pixel_fetch_buf.sv
// Show-ahead synchronous pixel FIFO with occupancy count; head reads 0 while empty.
module pixel_fetch_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign head   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pixel_fetch.sv
// Pops pixel addresses, reads SRAM one word at a time and queues pixels for the display.
// Optional underflow statistics counter enabled by macro PIXEL_FETCH_UNDERFLOW_STATS_EN.
module pixel_fetch
  import pixel_fetch_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = 8,
  parameter int SRAM_LAT  = 1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              iREADY_N,
  output logic              oREAD,
  input  logic [ADDR_W:0]   iADDRESS,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic              oSRAM_OE_N,
  input  logic [DATA_W-1:0] iSRAM_DQ,
  input  logic              iPIX_REQ,
  output logic              oPIX_VALID,
  output logic [DATA_W-1:0] oPIXEL,
  output logic [15:0]       oUNDERFLOW_CNT
);
  localparam int LAT_W = 2;

  state_t                     state;
  state_t                     state_nxt;
  logic                       armed;
  logic [LAT_W-1:0]           lat_cnt;
  logic                       push;
  logic [DATA_W-1:0]          push_data;
  logic                       pop;
  logic [$clog2(BUF_DEPTH):0] count;
  logic                       room;

  assign room       = (count < ($clog2(BUF_DEPTH)+1)'(BUF_DEPTH));
  assign pop        = iPIX_REQ && oPIX_VALID;
  assign oSRAM_OE_N = (state != ISSUE);

  // oREAD is combinational in IDLE; 'armed' keeps it low while reset is asserted.
  always_comb begin
    state_nxt = state;
    oREAD     = 1'b0;
    push      = 1'b0;
    push_data = DATA_W'(BLANK_PIXEL);
    case (state)
      IDLE: begin
        if (armed && !iREADY_N && room) begin
          oREAD     = 1'b1;
          state_nxt = POP;
        end
      end
      POP: begin
        if (iADDRESS[ADDR_W]) begin
          state_nxt = ISSUE;
        end else begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (lat_cnt == LAT_W'(SRAM_LAT-1)) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        push      = 1'b1;
        push_data = iSRAM_DQ;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      armed      <= 1'b0;
      lat_cnt    <= '0;
      oSRAM_ADDR <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (state == ISSUE) lat_cnt <= lat_cnt + 1'b1;
      else                lat_cnt <= '0;
      if (state == POP && iADDRESS[ADDR_W]) oSRAM_ADDR <= iADDRESS[ADDR_W-1:0];
    end
  end

  pixel_fetch_buf #(
    .DATA_W(DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .head     (oPIXEL),
    .valid    (oPIX_VALID),
    .count    (count)
  );

`ifdef PIXEL_FETCH_UNDERFLOW_STATS_EN
  logic [15:0] underflow_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      underflow_cnt <= '0;
    end else if (iPIX_REQ && !oPIX_VALID && underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

  assign oUNDERFLOW_CNT = underflow_cnt;
`else
  assign oUNDERFLOW_CNT = '0;
`endif
endmodule
